uart_word_packer: RTL
=====================

# uart_word_packer

- Receive-side counterpart of the 32-bit word serializer: collects bytes from the UART receiver and packs four consecutive bytes, MSB first, into one 32-bit word.
- Presents the packed word to the command/data logic over a valid/ready handshake.
- Flags a match against a configurable command word, and flags overrun and framing errors.

## Interface
Parameters:
- CMD_WORD, 32'h0100_0000, completed word value that produces a cmd_hit pulse
- TIMEOUT_CYCLES, 50000, allowed idle clk cycles between bytes of one word (1..2^20-1)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- rx_data  in  8  byte from UART receiver, stable while rx_done high
- rx_done  in  1  receiver byte-complete level; a byte is taken on its rising edge only
- word_ready  in  1  consumer accepts word_out when high with word_valid
- word_out  out  32  packed word, first received byte in [31:24]
- word_valid  out  1  word_out holds an unconsumed word
- cmd_hit  out  1  one-cycle pulse: completed word equals CMD_WORD
- overrun  out  1  one-cycle pulse: unconsumed word overwritten
- frame_err  out  1  one-cycle pulse: partial word discarded on timeout
- byte_cnt  out  2  bytes held in the current partial word (0..3)

## Operation
- Edge detect: rx_done_q registers rx_done (reset 0). The event is rx_done=1 and rx_done_q=0 at a clk edge. A level held high for N cycles yields one byte.
- State machine:
  - IDLE: byte_cnt=0. On an event, store the byte in shift[7:0], set byte_cnt=1, go to COLLECT.
  - COLLECT, byte_cnt<3, event: shift <= {shift[15:0], rx_data}, byte_cnt+1, clear the timeout counter.
  - COLLECT, byte_cnt=3, event (word completes):
    - word_out <= {shift[23:0], rx_data}, word_valid <= 1, byte_cnt <= 0, go to IDLE.
    - cmd_hit pulses if the completed value equals CMD_WORD.
  - COLLECT, no event: timeout counter (20 bits) increments.
- Handshake: word_valid stays high until an edge with word_valid & word_ready, then clears. word_out is unchanged while word_valid is high unless overwritten.
- Overrun: a word completes while word_valid=1 and word_ready=0.
  - word_out takes the new word and word_valid stays 1.
  - overrun pulses for 1 cycle.
- Simultaneous complete and accept (word_valid=1, word_ready=1, word completes): the old word is accepted, the new word is loaded, word_valid stays 1, no overrun.
- Reset mid-word: rst_n low immediately returns to IDLE and discards the partial word.

## Timing
- Reset values: word_out=0, word_valid=0, cmd_hit=0, overrun=0, frame_err=0, byte_cnt=0, state IDLE, timeout counter 0.
- Latency:
  - A byte is captured at the clk edge where the event is sampled.
  - word_valid, word_out and cmd_hit are visible in the cycle after the edge that samples the fourth event.
- Throughput: one byte per two cycles minimum, because rx_done must be low for at least one sampled cycle between bytes.
- Pulse outputs are high exactly one cycle and are registered.
- word_ready is ignored while word_valid=0.

## Configuration
- Macro: UART_WORD_PACKER_TIMEOUT_EN.
- Defined:
  - In COLLECT, when the counter reaches TIMEOUT_CYCLES with no event, go to IDLE, discard shift, set byte_cnt=0, pulse frame_err.
  - If an event and the timeout occur on the same edge, the event wins and the counter clears.
- Undefined:
  - No timeout counter is synthesized and frame_err is tied 0.
  - A partial word waits indefinitely for its remaining bytes.

## Test plan
- Bytes 12,34,56,78, rx_done high 3 cycles each, word_ready=1 -> one word_valid pulse with word_out=0x12345678; byte_cnt steps 1,2,3,0; cmd_hit=0.
- Bytes 01,00,00,00 with defaults -> word_out=0x01000000, cmd_hit high one cycle coincident with word_valid rising.
- word_ready=0, send 11223344 then AABBCCDD -> overrun pulses once; word_out=0xAABBCCDD held; word_valid stays 1 until word_ready=1, then clears next cycle.
- With UART_WORD_PACKER_TIMEOUT_EN and TIMEOUT_CYCLES=100:
  - Send 2 bytes, then idle 100 cycles -> frame_err pulses, byte_cnt=0.
  - Next 4 bytes A1,B2,C3,D4 -> word_out=0xA1B2C3D4.
- Send 3 bytes, pulse rst_n low 1 cycle, then send 4 bytes 01,02,03,04 -> word_out=0x01020304; no stale bytes.
- Word completes on the same edge word_ready=1 accepts a prior word -> word_valid continuous, overrun=0, new value present next cycle.

Source files
------------

// File: rtl/uart_word_packer.sv
// Packs four consecutive UART bytes (first byte in [31:24]) into a 32-bit word with a valid/ready output.
// Define UART_WORD_PACKER_TIMEOUT_EN to discard stalled partial words and pulse frame_err.
module uart_word_packer #(
  parameter logic [31:0] CMD_WORD       = 32'h0100_0000,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  input  logic        word_ready,
  output logic [31:0] word_out,
  output logic        word_valid,
  output logic        cmd_hit,
  output logic        overrun,
  output logic        frame_err,
  output logic [1:0]  byte_cnt
);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t      state_reg, state_next;
  logic        rx_done_q_reg;
  logic [23:0] shift_reg, shift_next;
  logic [1:0]  cnt_reg, cnt_next;
  logic [31:0] word_reg, word_next;
  logic        valid_reg, valid_next;
  logic        cmd_hit_reg, cmd_hit_next;
  logic        overrun_reg, overrun_next;
  logic        rx_event;
  logic [31:0] completed;

`ifdef UART_WORD_PACKER_TIMEOUT_EN
  localparam logic [19:0] TMO_LIMIT = 20'(TIMEOUT_CYCLES);
  logic [19:0] tmo_reg, tmo_next;
  logic        frame_err_reg, frame_err_next;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

  assign rx_event  = rx_done & ~rx_done_q_reg;
  assign completed = {shift_reg, rx_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      rx_done_q_reg <= 1'b0;
      shift_reg     <= '0;
      cnt_reg       <= '0;
      word_reg      <= '0;
      valid_reg     <= 1'b0;
      cmd_hit_reg   <= 1'b0;
      overrun_reg   <= 1'b0;
`ifdef UART_WORD_PACKER_TIMEOUT_EN
      tmo_reg       <= '0;
      frame_err_reg <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      rx_done_q_reg <= rx_done;
      shift_reg     <= shift_next;
      cnt_reg       <= cnt_next;
      word_reg      <= word_next;
      valid_reg     <= valid_next;
      cmd_hit_reg   <= cmd_hit_next;
      overrun_reg   <= overrun_next;
`ifdef UART_WORD_PACKER_TIMEOUT_EN
      tmo_reg       <= tmo_next;
      frame_err_reg <= frame_err_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    cnt_next     = cnt_reg;
    word_next    = word_reg;
    valid_next   = valid_reg;
    cmd_hit_next = 1'b0;
    overrun_next = 1'b0;
`ifdef UART_WORD_PACKER_TIMEOUT_EN
    tmo_next       = tmo_reg;
    frame_err_next = 1'b0;
`endif

    // An accept frees the slot; a word completing on the same edge reloads it below.
    if (valid_reg && word_ready) begin
      valid_next = 1'b0;
    end

    case (state_reg)
      IDLE: begin
        cnt_next = 2'd0;
`ifdef UART_WORD_PACKER_TIMEOUT_EN
        tmo_next = '0;
`endif
        if (rx_event) begin
          shift_next = {16'h0000, rx_data};
          cnt_next   = 2'd1;
          state_next = COLLECT;
        end
      end
      COLLECT: begin
        if (rx_event) begin
`ifdef UART_WORD_PACKER_TIMEOUT_EN
          tmo_next = '0;
`endif
          if (cnt_reg == 2'd3) begin
            word_next    = completed;
            valid_next   = 1'b1;
            overrun_next = valid_reg & ~word_ready;
            cmd_hit_next = (completed == CMD_WORD);
            cnt_next     = 2'd0;
            state_next   = IDLE;
          end else begin
            shift_next = {shift_reg[15:0], rx_data};
            cnt_next   = cnt_reg + 2'd1;
          end
        end else begin
`ifdef UART_WORD_PACKER_TIMEOUT_EN
          if (tmo_reg + 20'd1 == TMO_LIMIT) begin
            tmo_next       = '0;
            shift_next     = '0;
            cnt_next       = 2'd0;
            frame_err_next = 1'b1;
            state_next     = IDLE;
          end else begin
            tmo_next = tmo_reg + 20'd1;
          end
`endif
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 2'd0;
      end
    endcase
  end

  assign word_out   = word_reg;
  assign word_valid = valid_reg;
  assign cmd_hit    = cmd_hit_reg;
  assign overrun    = overrun_reg;
  assign byte_cnt   = cnt_reg;
`ifdef UART_WORD_PACKER_TIMEOUT_EN
  assign frame_err  = frame_err_reg;
`else
  assign frame_err  = 1'b0;
`endif

endmodule
